// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//   Write-side partner of the integer register file. Collects ALU results and
//   load-return data, formats loads by funct3 / byte offset, and drives the
//   single register file write port. Also counts retired register writes.
//
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   alu_valid / alu_ready      ALU result handshake (alu_rd, alu_result)
//   load_valid / load_ready    load return handshake (load_rd, load_funct3,
//                              load_addr_lsb, load_word)
//   rf_en, rf_rd, rf_data      register file write port (registered)
//   misalign_err               one-cycle pulse when an illegal load is dropped
//   retired                    count of completed writebacks (x0 included)
// -----------------------------------------------------------------------------
module writeback_unit #(
    parameter int LOAD_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_result,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [4:0]  load_rd,
    input  logic [2:0]  load_funct3,
    input  logic [1:0]  load_addr_lsb,
    input  logic [31:0] load_word,
    output logic        rf_en,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_data,
    output logic        misalign_err,
    output logic [31:0] retired
);

    localparam int PTR_W = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1;
    localparam int CNT_W = $clog2(LOAD_DEPTH) + 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [1:0]  lsb;
        logic [31:0] word;
    } load_ent_t;

    // Returns {legal, formatted_data}.
    function automatic logic [32:0] format_load(input logic [2:0]  f3,
                                                input logic [1:0]  lsb,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic        ok;
        logic [31:0] d;
        case (lsb)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lsb[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000: begin ok = 1'b1;         d = {{24{b[7]}}, b}; end
            3'b001: begin ok = !lsb[0];      d = {{16{h[15]}}, h}; end
            3'b010: begin ok = (lsb == 2'd0); d = w; end
            3'b100: begin ok = 1'b1;         d = {24'd0, b}; end
            3'b101: begin ok = !lsb[0];      d = {16'd0, h}; end
            default: begin ok = 1'b0;        d = w; end
        endcase
        return {ok, d};
    endfunction

    load_ent_t        mem_q [LOAD_DEPTH];
    logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rf_en_q, misalign_q;
    logic [4:0]       rf_rd_q;
    logic [31:0]      rf_data_q, retired_q;

    logic             push, pop, alu_take;
    load_ent_t        head;
    logic [32:0]      fmt;
    logic             wb_valid, wb_legal;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;

    // Readiness comes from the registered occupancy only; reset blocks both.
    assign load_ready = !rst && (count_q < CNT_W'(LOAD_DEPTH));
    assign alu_ready  = !rst && (count_q == '0);

    assign push     = load_valid && load_ready;
    assign pop      = (count_q != '0);
    assign alu_take = alu_valid && alu_ready;

    assign head = mem_q[rptr_q];
    assign fmt  = format_load(head.funct3, head.lsb, head.word);

    always_comb begin
        wb_valid = 1'b0;
        wb_legal = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
        // Buffered loads always win: they are older than any pending ALU result.
        if (pop) begin
            wb_valid = 1'b1;
            wb_legal = fmt[32];
            wb_rd    = head.rd;
            wb_data  = fmt[31:0];
        end else if (alu_take) begin
            wb_valid = 1'b1;
            wb_legal = 1'b1;
            wb_rd    = alu_rd;
            wb_data  = alu_result;
        end
    end

    always_comb begin
        rptr_d  = pop  ? rptr_q + PTR_W'(1) : rptr_q;
        wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= '{rd: load_rd, funct3: load_funct3,
                               lsb: load_addr_lsb, word: load_word};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            rf_en_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_data_q  <= '0;
            misalign_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            count_q    <= count_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            // x0 writes retire and stay visible on rd/data, but never assert en.
            rf_en_q    <= wb_valid && wb_legal && (wb_rd != 5'd0);
            misalign_q <= wb_valid && !wb_legal;
            if (wb_valid && wb_legal) begin
                rf_rd_q   <= wb_rd;
                rf_data_q <= wb_data;
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign rf_en        = rf_en_q;
    assign rf_rd        = rf_rd_q;
    assign rf_data      = rf_data_q;
    assign misalign_err = misalign_q;
    assign retired      = retired_q;

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
    localparam int LD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        load_valid, load_ready;
    logic [4:0]  load_rd;
    logic [2:0]  load_funct3;
    logic [1:0]  load_addr_lsb;
    logic [31:0] load_word;
    logic        rf_en;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic        misalign_err;
    logic [31:0] retired;

    int checks = 0;
    int failures = 0;

    writeback_unit #(.LOAD_DEPTH(LD)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_result(alu_result),
        .load_valid(load_valid), .load_ready(load_ready), .load_rd(load_rd),
        .load_funct3(load_funct3), .load_addr_lsb(load_addr_lsb), .load_word(load_word),
        .rf_en(rf_en), .rf_rd(rf_rd), .rf_data(rf_data),
        .misalign_err(misalign_err), .retired(retired)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [1:0]  lsb;
        logic [31:0] w;
    } ld_t;

    ld_t         mq[$];
    logic        m_en, m_err;
    logic [4:0]  m_rd;
    logic [31:0] m_data, m_ret;

    function automatic logic [32:0] ref_fmt(input logic [2:0] f3, input logic [1:0] lsb,
                                            input logic [31:0] w);
        logic [31:0] s;
        int          off;
        off = int'(lsb);
        s = w >> (8 * off);
        case (f3)
            3'd0: return {1'b1, {{24{s[7]}}, s[7:0]}};
            3'd4: return {1'b1, {24'd0, s[7:0]}};
            3'd1: return {(off % 2 == 0), {{16{s[15]}}, s[15:0]}};
            3'd5: return {(off % 2 == 0), {16'd0, s[15:0]}};
            3'd2: return {(off == 0), w};
            default: return {1'b0, w};
        endcase
    endfunction

    // Advance the model with the inputs presented this cycle, then clock the DUT.
    task automatic tick();
        ld_t         e;
        logic [32:0] f;
        bit          lacc;
        if (rst) begin
            mq.delete();
            m_en = 0; m_err = 0; m_rd = 0; m_data = 0; m_ret = 0;
        end else begin
            lacc  = load_valid && (mq.size() < LD);
            m_en  = 0;
            m_err = 0;
            if (mq.size() > 0) begin
                e = mq.pop_front();
                f = ref_fmt(e.f3, e.lsb, e.w);
                if (!f[32]) m_err = 1;
                else begin
                    m_rd = e.rd; m_data = f[31:0]; m_en = (e.rd != 0); m_ret = m_ret + 1;
                end
            end else if (alu_valid) begin
                m_rd = alu_rd; m_data = alu_result; m_en = (alu_rd != 0); m_ret = m_ret + 1;
            end
            if (lacc) mq.push_back('{rd: load_rd, f3: load_funct3, lsb: load_addr_lsb, w: load_word});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer_load(input logic [4:0] rd, input logic [2:0] f3,
                              input logic [1:0] lsb, input logic [31:0] w);
        load_valid = 1; load_rd = rd; load_funct3 = f3; load_addr_lsb = lsb; load_word = w;
    endtask

    task automatic offer_alu(input logic [4:0] rd, input logic [31:0] v);
        alu_valid = 1; alu_rd = rd; alu_result = v;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1;
        offer_alu(5'd1, 32'h1111);
        offer_load(5'd2, 3'd2, 2'd0, 32'h2222);
        tick();
        tick();
        checks++; if (rf_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%0h exp=0", rf_en); end
        checks++; if (rf_rd !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0h exp=0", rf_rd); end
        checks++; if (rf_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%0h exp=0", rf_data); end
        checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", misalign_err); end
        checks++; if (retired !== 32'd0) begin failures++; $display("FAIL reset_retired got=%0h exp=0", retired); end
        checks++; if (alu_ready !== 1'b0) begin failures++; $display("FAIL reset_alu_ready got=%0h exp=0", alu_ready); end
        checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL reset_load_ready got=%0h exp=0", load_ready); end
        rst = 0; alu_valid = 0; load_valid = 0;
        #1;
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL post_reset_alu_ready got=%0h exp=1", alu_ready); end
        checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL post_reset_load_ready got=%0h exp=1", load_ready); end
        tick();
        checks++; if (rf_en !== 1'b0) begin failures++; $display("FAIL reset_discard_en got=%0h exp=0", rf_en); end
    endtask

    task automatic test_alu();
        offer_alu(5'd5, 32'hDEADBEEF);
        tick();
        alu_valid = 0;
        checks++; if (rf_en !== 1'b1) begin failures++; $display("FAIL alu_en got=%0h exp=1", rf_en); end
        checks++; if (rf_rd !== 5'd5) begin failures++; $display("FAIL alu_rd got=%0h exp=5", rf_rd); end
        checks++; if (rf_data !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_data got=%0h exp=deadbeef", rf_data); end
        checks++; if (retired !== 32'd1) begin failures++; $display("FAIL alu_retired got=%0h exp=1", retired); end
        tick();
        checks++; if (rf_en !== 1'b0) begin failures++; $display("FAIL alu_en_drop got=%0h exp=0", rf_en); end
    endtask

    task automatic test_load_format();
        logic [2:0]  f3s [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        logic [1:0]  lsbs[5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
        logic [31:0] exps[5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
        logic [31:0] r0;
        for (int i = 0; i < 5; i++) begin
            r0 = retired;
            offer_load(5'(10 + i), f3s[i], lsbs[i], 32'h80FF_7F01);
            tick();
            load_valid = 0;
            checks++; if (rf_en !== 1'b0) begin failures++; $display("FAIL ld%0d_early_en got=%0h exp=0", i, rf_en); end
            tick();
            checks++; if (rf_en !== 1'b1) begin failures++; $display("FAIL ld%0d_en got=%0h exp=1", i, rf_en); end
            checks++; if (rf_rd !== 5'(10 + i)) begin failures++; $display("FAIL ld%0d_rd got=%0h exp=%0h", i, rf_rd, 10 + i); end
            checks++; if (rf_data !== exps[i]) begin failures++; $display("FAIL ld%0d_data got=%0h exp=%0h", i, rf_data, exps[i]); end
            checks++; if (retired !== r0 + 1) begin failures++; $display("FAIL ld%0d_retired got=%0h exp=%0h", i, retired, r0 + 1); end
        end
    endtask

    task automatic test_simultaneous();
        offer_load(5'd3, 3'd2, 2'd0, 32'h1234_5678);
        offer_alu(5'd4, 32'hA5A5_0004);
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL sim_alu_ready0 got=%0h exp=1", alu_ready); end
        tick();
        load_valid = 0;
        offer_alu(5'd6, 32'h0000_6666);
        checks++; if (rf_rd !== 5'd4 || rf_en !== 1'b1) begin failures++; $display("FAIL sim_first rd=%0h en=%0h exp rd=4 en=1", rf_rd, rf_en); end
        checks++; if (rf_data !== 32'hA5A5_0004) begin failures++; $display("FAIL sim_first_data got=%0h exp=a5a50004", rf_data); end
        checks++; if (alu_ready !== 1'b0) begin failures++; $display("FAIL sim_alu_held got=%0h exp=0", alu_ready); end
        tick();
        checks++; if (rf_rd !== 5'd3 || rf_data !== 32'h1234_5678) begin failures++; $display("FAIL sim_second rd=%0h data=%0h exp rd=3 data=12345678", rf_rd, rf_data); end
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL sim_alu_release got=%0h exp=1", alu_ready); end
        tick();
        alu_valid = 0;
        checks++; if (rf_rd !== 5'd6 || rf_data !== 32'h6666 || rf_en !== 1'b1) begin failures++; $display("FAIL sim_third rd=%0h data=%0h en=%0h exp rd=6 data=6666 en=1", rf_rd, rf_data, rf_en); end
        tick();
    endtask

    task automatic test_back_to_back();
        offer_load(5'd10, 3'd2, 2'd0, 32'hA0);
        tick();
        offer_load(5'd11, 3'd2, 2'd0, 32'hB0);
        offer_alu(5'd9, 32'h99);
        checks++; if (alu_ready !== 1'b0 || load_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready alu=%0h load=%0h exp alu=0 load=1", alu_ready, load_ready); end
        tick();
        checks++; if (rf_rd !== 5'd10 || rf_data !== 32'hA0) begin failures++; $display("FAIL b2b_w1 rd=%0h data=%0h exp rd=a data=a0", rf_rd, rf_data); end
        offer_load(5'd12, 3'd2, 2'd0, 32'hC0);
        checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL b2b_load_ready got=%0h exp=1", load_ready); end
        tick();
        load_valid = 0;
        checks++; if (rf_rd !== 5'd11 || rf_data !== 32'hB0) begin failures++; $display("FAIL b2b_w2 rd=%0h data=%0h exp rd=b data=b0", rf_rd, rf_data); end
        checks++; if (alu_ready !== 1'b0) begin failures++; $display("FAIL b2b_alu_still_held got=%0h exp=0", alu_ready); end
        tick();
        checks++; if (rf_rd !== 5'd12 || rf_data !== 32'hC0) begin failures++; $display("FAIL b2b_w3 rd=%0h data=%0h exp rd=c data=c0", rf_rd, rf_data); end
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL b2b_alu_ready got=%0h exp=1", alu_ready); end
        tick();
        alu_valid = 0;
        checks++; if (rf_rd !== 5'd9 || rf_data !== 32'h99 || rf_en !== 1'b1) begin failures++; $display("FAIL b2b_alu_last rd=%0h data=%0h en=%0h exp rd=9 data=99 en=1", rf_rd, rf_data, rf_en); end
        tick();
        checks++; if (rf_en !== 1'b0) begin failures++; $display("FAIL b2b_idle_en got=%0h exp=0", rf_en); end
    endtask

    task automatic test_illegal();
        logic [2:0] f3s [2] = '{3'd2, 3'd3};
        logic [1:0] lsbs[2] = '{2'd2, 2'd0};
        logic [31:0] r0;
        for (int i = 0; i < 2; i++) begin
            r0 = retired;
            offer_load(5'd7, f3s[i], lsbs[i], 32'hCAFE_F00D);
            tick();
            load_valid = 0;
            tick();
            checks++; if (misalign_err !== 1'b1) begin failures++; $display("FAIL ill%0d_err got=%0h exp=1", i, misalign_err); end
            checks++; if (rf_en !== 1'b0) begin failures++; $display("FAIL ill%0d_en got=%0h exp=0", i, rf_en); end
            checks++; if (retired !== r0) begin failures++; $display("FAIL ill%0d_retired got=%0h exp=%0h", i, retired, r0); end
            tick();
            checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL ill%0d_err_pulse got=%0h exp=0", i, misalign_err); end
        end
        r0 = retired;
        offer_alu(5'd0, 32'h1357);
        tick();
        alu_valid = 0;
        checks++; if (rf_en !== 1'b0) begin failures++; $display("FAIL x0_en got=%0h exp=0", rf_en); end
        checks++; if (rf_rd !== 5'd0 || rf_data !== 32'h1357) begin failures++; $display("FAIL x0_trace rd=%0h data=%0h exp rd=0 data=1357", rf_rd, rf_data); end
        checks++; if (retired !== r0 + 1) begin failures++; $display("FAIL x0_retired got=%0h exp=%0h", retired, r0 + 1); end
        tick();
    endtask

    task automatic test_wrap();
        force dut.retired_q = 32'hFFFF_FFFE;
        #1;
        release dut.retired_q;
        m_ret = 32'hFFFF_FFFE;
        #1;
        checks++; if (retired !== 32'hFFFF_FFFE) begin failures++; $display("FAIL wrap_preload got=%0h exp=fffffffe", retired); end
        offer_alu(5'd1, 32'h1);
        tick();
        checks++; if (retired !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_max got=%0h exp=ffffffff", retired); end
        tick();
        alu_valid = 0;
        checks++; if (retired !== 32'd0) begin failures++; $display("FAIL wrap_zero got=%0h exp=0", retired); end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        offer_load(5'd20, 3'd2, 2'd0, 32'h20);
        tick();
        offer_load(5'd21, 3'd2, 2'd0, 32'h21);
        tick();
        offer_load(5'd22, 3'd2, 2'd0, 32'h22);
        rst = 1;
        tick();
        checks++; if (rf_en !== 0 || rf_rd !== 0 || rf_data !== 0 || misalign_err !== 0 || retired !== 0) begin
            failures++; $display("FAIL drain_reset en=%0h rd=%0h data=%0h err=%0h ret=%0h exp all 0", rf_en, rf_rd, rf_data, misalign_err, retired);
        end
        rst = 0; load_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rf_en !== 1'b0 || retired !== 32'd0) begin failures++; $display("FAIL drain_flushed%0d en=%0h ret=%0h exp en=0 ret=0", i, rf_en, retired); end
        end
    endtask

    task automatic test_random();
        bit exp_lrdy, exp_ardy;
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(63) == 0);
            alu_valid  = $urandom_range(1);
            alu_rd     = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
            alu_result = $urandom;
            load_valid = ($urandom_range(2) != 0);
            load_rd    = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
            load_funct3   = 3'($urandom);
            load_addr_lsb = 2'($urandom);
            load_word     = $urandom;
            tick();
            exp_lrdy = !rst && (mq.size() < LD);
            exp_ardy = !rst && (mq.size() == 0);
            checks++; if (rf_en !== m_en) begin failures++; $display("FAIL rnd%0d_en got=%0h exp=%0h", i, rf_en, m_en); end
            checks++; if (rf_rd !== m_rd) begin failures++; $display("FAIL rnd%0d_rd got=%0h exp=%0h", i, rf_rd, m_rd); end
            checks++; if (rf_data !== m_data) begin failures++; $display("FAIL rnd%0d_data got=%0h exp=%0h", i, rf_data, m_data); end
            checks++; if (misalign_err !== m_err) begin failures++; $display("FAIL rnd%0d_err got=%0h exp=%0h", i, misalign_err, m_err); end
            checks++; if (retired !== m_ret) begin failures++; $display("FAIL rnd%0d_retired got=%0h exp=%0h", i, retired, m_ret); end
            checks++; if (load_ready !== exp_lrdy) begin failures++; $display("FAIL rnd%0d_load_ready got=%0h exp=%0h", i, load_ready, exp_lrdy); end
            checks++; if (alu_ready !== exp_ardy) begin failures++; $display("FAIL rnd%0d_alu_ready got=%0h exp=%0h", i, alu_ready, exp_ardy); end
        end
        rst = 0; alu_valid = 0; load_valid = 0;
        tick(); tick(); tick();
    endtask

    initial begin
        rst = 1; alu_valid = 0; alu_rd = 0; alu_result = 0;
        load_valid = 0; load_rd = 0; load_funct3 = 0; load_addr_lsb = 0; load_word = 0;
        test_reset();
        test_alu();
        test_load_format();
        test_simultaneous();
        test_back_to_back();
        test_illegal();
        test_wrap();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
